// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package ifetch_pkg;

  localparam int INST_WIDTH = 32;
  localparam int PC_WIDTH   = 32;

  typedef logic [PC_WIDTH-1:0]   pc_t;
  typedef logic [INST_WIDTH-1:0] inst_t;

  localparam pc_t PC_STEP = 32'd4;

  typedef struct packed {
    pc_t   pc;
    inst_t inst;
  } fetch_entry_t;

  function automatic pc_t next_pc(input pc_t pc);
    return pc + PC_STEP;
  endfunction

  function automatic logic is_misaligned(input pc_t pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/ifetch_if.sv
// Fetch-stage bus: ROM address/data, redirect from execute, decode handshake, fault.
interface ifetch_if;
  import ifetch_pkg::*;

  pc_t   rom_addr;
  inst_t rom_rd;
  logic  redirect_valid;
  pc_t   redirect_pc;
  logic  out_valid;
  logic  out_ready;
  inst_t out_inst;
  pc_t   out_pc;
  logic  fault;

  modport master (
    output rom_addr,
    input  rom_rd,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_inst,
    output out_pc,
    output fault
  );

  modport slave (
    input  rom_addr,
    output rom_rd,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_inst,
    input  out_pc,
    input  fault
  );

endinterface

// File: rtl/ifetch_fifo.sv
// Circular FIFO of tagged fetch entries; flush beats push, push+pop legal when full.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic           push,
  input  logic           pop,
  input  logic           flush,
  input  fetch_entry_t   entry,
  output logic [CW-1:0]  count,
  output fetch_entry_t   head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  fetch_entry_t  mem [DEPTH];
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && (count != '0);

  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= inc_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= inc_ptr(rd_ptr);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // NOTE: storage is not reset; the head is forced to zero while empty, so stale words never leak.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= entry;
  end

  assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/ifetch.sv
// Instruction fetch stage: PC, one-deep ROM read tracking, credit-limited FIFO to decode.
// Optional: define IFETCH_MISALIGN_TRAP_EN to trap misaligned redirect targets via sticky fault.
module ifetch
  import ifetch_pkg::*;
#(
  parameter pc_t RESET_PC  = 32'h0000_0000,
  parameter int  BUF_DEPTH = 2
) (
  input logic CLK,
  input logic RST_N,
  ifetch_if.master bus
);

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam logic [CW:0] DEPTH_LIMIT = (CW + 1)'(BUF_DEPTH);

  pc_t           pc;
  pc_t           pc_nxt;
  logic          inflight_v;
  logic          inflight_v_nxt;
  pc_t           inflight_pc;
  pc_t           inflight_pc_nxt;
  logic          fault_q;
  pc_t           redirect_target;

  logic          push;
  logic          pop;
  logic          flush;
  logic          issue;
  logic          out_valid;
  logic [CW-1:0] count;
  fetch_entry_t  head;
  fetch_entry_t  entry;
  logic [CW:0]   credit_used;

`ifdef IFETCH_MISALIGN_TRAP_EN
  assign redirect_target = bus.redirect_pc;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fault_q <= 1'b0;
    end else if (bus.redirect_valid && is_misaligned(bus.redirect_pc)) begin
      fault_q <= 1'b1;
    end
  end
`else
  logic redirect_lsb_unused;

  assign redirect_lsb_unused = ^bus.redirect_pc[1:0];
  assign redirect_target     = {bus.redirect_pc[PC_WIDTH-1:2], 2'b00};
  assign fault_q             = 1'b0;
`endif

  assign out_valid = (count != '0);
  assign pop       = out_valid && bus.out_ready;
  assign entry     = '{pc: inflight_pc, inst: bus.rom_rd};

  // Slots already committed: buffered + in flight, minus the one decode takes this edge.
  assign credit_used = {1'b0, count}
                     + {{CW{1'b0}}, inflight_v}
                     - {{CW{1'b0}}, pop};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    pc_nxt          = pc;
    inflight_v_nxt  = 1'b0;
    inflight_pc_nxt = inflight_pc;
    flush           = 1'b0;
    push            = 1'b0;
    issue           = 1'b0;

    if (bus.redirect_valid) begin
      flush  = 1'b1;
      pc_nxt = redirect_target;
    end else begin
      push  = inflight_v;
      issue = !fault_q && (credit_used < DEPTH_LIMIT);
      if (issue) begin
        inflight_v_nxt  = 1'b1;
        inflight_pc_nxt = pc;
        pc_nxt          = next_pc(pc);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc          <= RESET_PC;
      inflight_v  <= 1'b0;
      inflight_pc <= '0;
    end else begin
      pc          <= pc_nxt;
      inflight_v  <= inflight_v_nxt;
      inflight_pc <= inflight_pc_nxt;
    end
  end

  ifetch_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RST_N (RST_N),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .entry (entry),
    .count (count),
    .head  (head)
  );

  assign bus.rom_addr  = pc;
  assign bus.out_valid = out_valid;
  assign bus.out_inst  = head.inst;
  assign bus.out_pc    = head.pc;
  assign bus.fault     = fault_q;

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: ROM model returns 0x11*(word index+1) for each word address.
module tb_ifetch;

  logic CLK;
  logic RST_N;
  int   n_checks;
  int   n_pass;
  int   acc_pc4;

  ifetch_if bus ();

  ifetch #(
    .RESET_PC  (32'h0000_0000),
    .BUF_DEPTH (2)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    return 32'h11 * ((addr >> 2) + 32'd1);
  endfunction

  // Synchronous ROM: data for the address seen at an edge appears after that edge.
  always @(posedge CLK) bus.rom_rd <= rom_word(bus.rom_addr);

  always @(posedge CLK)
    if (RST_N && bus.out_valid && bus.out_ready && bus.out_pc == 32'h4) acc_pc4++;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] pc);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_pc"}, bus.out_pc, pc);
    check({tag, "_inst"}, bus.out_inst, rom_word(pc));
  endtask

  task automatic expect_idle(input string tag);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
  endtask

  task automatic redirect(input logic [31:0] target);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = target;
    step();
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
  endtask

  initial begin
    n_checks           = 0;
    n_pass             = 0;
    acc_pc4            = 0;
    RST_N              = 1'b0;
    bus.out_ready      = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;

    repeat (2) @(posedge CLK);
    #1;
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_inst", bus.out_inst, 32'h0);
    check("rst_pc", bus.out_pc, 32'h0);
    check("rst_rom_addr", bus.rom_addr, 32'h0);
    check("rst_fault", 32'(bus.fault), 32'd0);

    // Start-up: issue at edge 1, first instruction visible after edge 2.
    RST_N = 1'b1;
    step();
    expect_idle("e1");
    check("e1_rom_addr", bus.rom_addr, 32'h4);
    step(); expect_out("e2", 32'h0);
    step(); expect_out("e3", 32'h4);
    step(); expect_out("e4", 32'h8);

    // Back-pressure: head must hold, FIFO never overfills.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      expect_out("stall", 32'h8);
      check("stall_count_le2", 32'(dut.u_fifo.count <= 2), 32'd1);
    end
    bus.out_ready = 1'b1;
    step(); expect_out("rel0", 32'hC);
    step(); expect_out("rel1", 32'h10);

    // Fill the FIFO, then redirect with it full.
    bus.out_ready = 1'b0;
    step(); expect_out("fill", 32'h10);
    check("fill_count", 32'(dut.u_fifo.count), 32'd2);
    bus.out_ready = 1'b1;
    redirect(32'h40);
    expect_idle("rd40_a");
    step(); expect_idle("rd40_b");
    step(); expect_out("rd40_c", 32'h40);
    step(); expect_out("rd40_d", 32'h44);

    // Redirect on the same edge decode accepts pc 0x4.
    redirect(32'h0);
    expect_idle("rd0_a");
    step(); expect_idle("rd0_b");
    step(); expect_out("rd0_c", 32'h0);
    step(); expect_out("rd0_d", 32'h4);
    redirect(32'h80);
    expect_idle("rd80_a");
    step(); expect_idle("rd80_b");
    step(); expect_out("rd80_c", 32'h80);
    step(); expect_out("rd80_d", 32'h84);
    check("pc4_accepted_twice_total", 32'(acc_pc4), 32'd2);

    // Mid-stream asynchronous reset.
    redirect(32'h18);
    step();
    step(); expect_out("pre_rst_a", 32'h18);
    step(); expect_out("pre_rst_b", 32'h1C);
    step(); expect_out("pre_rst_c", 32'h20);
    RST_N = 1'b0;
    #2;
    check("arst_valid", 32'(bus.out_valid), 32'd0);
    check("arst_pc", bus.out_pc, 32'h0);
    check("arst_rom_addr", bus.rom_addr, 32'h0);
    step();
    check("arst_hold_valid", 32'(bus.out_valid), 32'd0);
    RST_N = 1'b1;
    step(); expect_idle("post_rst_e1");
    step(); expect_out("post_rst_e2", 32'h0);

    // Misaligned redirect.
    redirect(32'h42);
    expect_idle("mis_a");
`ifdef IFETCH_MISALIGN_TRAP_EN
    check("mis_fault", 32'(bus.fault), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      expect_idle("mis_trap");
      check("mis_trap_fault", 32'(bus.fault), 32'd1);
      check("mis_trap_rom_addr", bus.rom_addr, 32'h42);
    end
`else
    check("mis_fault", 32'(bus.fault), 32'd0);
    step(); expect_idle("mis_b");
    step(); expect_out("mis_c", 32'h40);
    step(); expect_out("mis_d", 32'h44);
    check("mis_fault_end", 32'(bus.fault), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
